imem_fetch_arbiter: RTL

Owns the single port of `instruction_memory` (14-bit byte address, 32-bit word, combinational read) and shares it between a boot-time program loader and the core's fetch stage. A small state machine grants the port to exactly one requester at a time. In LOAD it streams loader words into consecutive word addresses; in RUN it serves core fetches through a registered instruction output with stall and misalignment-fault handling.

---
 rtl/imem_fetch_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/imem_fetch_arbiter.sv
// Shares the single instruction-memory port between the boot loader (LOAD)
// and the core fetch stage (RUN); IDLE and FAULT park the port.
module imem_fetch_arbiter #(
  parameter int N         = 32,
  parameter int A         = 14,
  parameter int MAX_WORDS = 4096
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_start,
  input  logic         load_valid,
  input  logic [N-1:0] load_data,
  input  logic         load_last,
  output logic         load_ready,
  input  logic         run_start,
  input  logic         fetch_req,
  input  logic [A-1:0] fetch_addr,
  input  logic         fetch_stall,
  output logic         fetch_valid,
  output logic [N-1:0] fetch_instr,
  output logic         fetch_fault,
  output logic [A-1:0] mem_address,
  output logic [N-1:0] mem_wdata,
  output logic         mem_we,
  input  logic [N-1:0] mem_rdata,
  output logic [1:0]   state,
  output logic [12:0]  load_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [12:0] MAX_CNT = 13'(MAX_WORDS);

  state_t         state_q, state_d;
  logic [12:0]    count_q, count_d;
  logic [N-1:0]   instr_q, instr_d;
  logic           valid_q, valid_d;
  logic           fault_q, fault_d;
  logic [A-1:0]   last_addr_q, last_addr_d;
  logic           issue_s;

  assign issue_s = fetch_req && !fetch_stall;

  // Next-state logic and combinational memory-port drive
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    fault_d     = fault_q;
    last_addr_d = last_addr_q;
    mem_address = '0;
    mem_wdata   = '0;
    mem_we      = 1'b0;
    load_ready  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d = ST_LOAD;
          count_d = 13'd0;
          valid_d = 1'b0;
        end else if (run_start) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        load_ready = (count_q < MAX_CNT);
        if (load_ready && load_valid) begin
          mem_we      = 1'b1;
          mem_address = {count_q[A-3:0], 2'b00};
          mem_wdata   = load_data;
          count_d     = count_q + 13'd1;
          if (load_last || (count_q == MAX_CNT - 13'd1)) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (issue_s) begin
          mem_address = fetch_addr;
          last_addr_d = fetch_addr;
          if (fetch_addr[1:0] == 2'b00) begin
            instr_d = mem_rdata;
            valid_d = 1'b1;
          end else begin
            valid_d = 1'b0;
            fault_d = 1'b1;
            state_d = ST_FAULT;
          end
        end else begin
          // Port keeps showing the last issued address while idle or stalled
          mem_address = last_addr_q;
          if (!fetch_stall) begin
            valid_d = 1'b0;
          end else begin
            valid_d = valid_q;
          end
        end
        if (load_start) begin
          state_d = ST_LOAD;
          count_d = 13'd0;
          valid_d = 1'b0;
          fault_d = 1'b0;
        end else begin
          count_d = count_q;
        end
      end
      ST_FAULT: begin
        if (load_start) begin
          state_d = ST_LOAD;
          count_d = 13'd0;
          valid_d = 1'b0;
          fault_d = 1'b0;
        end else begin
          state_d = ST_FAULT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A word presented during the reset cycle must never reach memory
    if (!rst_n) begin
      mem_address = '0;
      mem_wdata   = '0;
      mem_we      = 1'b0;
      load_ready  = 1'b0;
    end else begin
      mem_we      = mem_we;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= 13'd0;
      instr_q     <= '0;
      valid_q     <= 1'b0;
      fault_q     <= 1'b0;
      last_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      fault_q     <= fault_d;
      last_addr_q <= last_addr_d;
    end
  end

  assign state       = state_q;
  assign load_count  = count_q;
  assign fetch_instr = instr_q;
  assign fetch_valid = valid_q;
  assign fetch_fault = fault_q;

endmodule
